// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings a PLL out of reset. It pulses the PLL reset pin, waits for LOCK, and
// requires LOCK to stay up for a qualification window before it releases the
// system reset. An attempt that does not reach RUN within the lock timeout is
// retried. Once MAX_RETRIES attempts have timed out the sequencer parks in FAIL
// until it sees a restart request or rst_n. A lock loss while in RUN is counted
// and the sequence starts again.
//
// Ports
//   clk        in   reference clock (PLL input clock); rising edge only
//   rst_n      in   asynchronous active-low reset
//   pll_lock   in   PLL LOCK, asynchronous to clk; passes through a 2-flop sync
//   restart    in   single-cycle synchronous restart request, highest priority
//   pll_reset  out  PLL RESET pin, active-high
//   sys_rst_n  out  system reset, active-low, released only in RUN
//   locked_ok  out  high only in RUN
//   fail       out  high only in FAIL
//   retry_cnt  out  timed-out attempts in the current sequence
//   loss_cnt   out  lock losses seen in RUN, saturates at 255
//   state      out  current state encoding
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RESET_PLL | pll_reset held high for RESET_CYCLES cycles
// WAIT_LOCK | waiting for the synced lock; timeout counter running
// STABLE    | lock must stay high LOCK_STABLE_CYCLES cycles; timeout running
// RUN       | system reset released; lock loss restarts the sequence
// FAIL      | retries exhausted; waits for restart or rst_n
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  // Counters hold at most PARAM-1, so PARAM+1 keeps the width >= 1 bit.
  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam int SC_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RESET_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      RETRY_MX = 4'(MAX_RETRIES);

  state_e          state_q, state_d;
  logic            sync1_q, lock_s_q;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [SC_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            pll_reset_q, sys_rst_n_q, locked_ok_q, fail_q;
  logic            timeout;
  logic [3:0]      retry_inc;

  // Lock synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  assign timeout   = ((state_q == WAIT_LOCK) || (state_q == STABLE)) &&
                     (to_cnt_q == TO_LAST);
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    stab_cnt_d = stab_cnt_q;
    to_cnt_d   = to_cnt_q;
    retry_d    = retry_q;
    loss_d     = loss_q;

    if (restart) begin
      state_d    = RESET_PLL;
      rst_cnt_d  = '0;
      stab_cnt_d = '0;
      retry_d    = 4'd0;
      // A loss in the same cycle as a restart is still counted.
      if ((state_q == RUN) && !lock_s_q && (loss_q != 8'hFF)) begin
        loss_d = loss_q + 8'd1;
      end
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (rst_cnt_q == RC_LAST) begin
            state_d    = WAIT_LOCK;
            rst_cnt_d  = '0;
            to_cnt_d   = '0;
            stab_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end

        WAIT_LOCK, STABLE: begin
          if (timeout) begin
            // Timeout wins over a lock seen in the same cycle.
            retry_d    = retry_inc;
            state_d    = (retry_inc == RETRY_MX) ? FAIL : RESET_PLL;
            rst_cnt_d  = '0;
            stab_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (state_q == WAIT_LOCK) begin
              if (lock_s_q) begin
                state_d    = STABLE;
                stab_cnt_d = '0;
              end
            end else if (!lock_s_q) begin
              // Chatter: requalify, but keep the attempt's timeout running.
              state_d    = WAIT_LOCK;
              stab_cnt_d = '0;
            end else if (stab_cnt_q == SC_LAST) begin
              state_d    = RUN;
              stab_cnt_d = '0;
            end else begin
              stab_cnt_d = stab_cnt_q + 1'b1;
            end
          end
        end

        RUN: begin
          if (!lock_s_q) begin
            state_d   = RESET_PLL;
            rst_cnt_d = '0;
            retry_d   = 4'd0;
            if (loss_q != 8'hFF) begin
              loss_d = loss_q + 8'd1;
            end
          end
        end

        FAIL: begin
          state_d = FAIL;
        end

        default: begin
          state_d   = RESET_PLL;
          rst_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they always equal a decode
  // of the current state without a combinational path to the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      rst_cnt_q   <= '0;
      stab_cnt_q  <= '0;
      to_cnt_q    <= '0;
      retry_q     <= 4'd0;
      loss_q      <= 8'd0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_ok_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      to_cnt_q    <= to_cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= (state_d == RESET_PLL);
      sys_rst_n_q <= (state_d == RUN);
      locked_ok_q <= (state_d == RUN);
      fail_q      <= (state_d == FAIL);
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign locked_ok = locked_ok_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short parameters
// (RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2).
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point, so "edge N" comments count rising edges since the marked event.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       locked_ok;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RESET_CYCLES       (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .sys_rst_n (sys_rst_n),
    .locked_ok (locked_ok),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},     32'(state),     32'd0);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
    chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 32'd0);
    chk({tag, "_locked_ok"}, 32'(locked_ok), 32'd0);
    chk({tag, "_fail"},      32'(fail),      32'd0);
    chk({tag, "_retry"},     32'(retry_cnt), 32'd0);
    chk({tag, "_loss"},      32'(loss_cnt),  32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;

    // Reset values
    tick(3);
    chk_reset_values("rst");

    // Nominal: lock sampled at edge 10 -> STABLE at 12 -> RUN at 20
    rst_n = 1'b1;
    tick(3);
    chk("nom_rstpll_e3", 32'(state), 32'd0);
    chk("nom_pllrst_e3", 32'(pll_reset), 32'd1);
    tick(1);
    chk("nom_wait_e4", 32'(state), 32'd1);
    chk("nom_pllrst_e4", 32'(pll_reset), 32'd0);
    tick(5);
    pll_lock = 1'b1;
    tick(10);
    chk("nom_stable_e19", 32'(state), 32'd2);
    chk("nom_sysrst_e19", 32'(sys_rst_n), 32'd0);
    tick(1);
    chk("nom_run_e20", 32'(state), 32'd3);
    chk("nom_sysrst_e20", 32'(sys_rst_n), 32'd1);
    chk("nom_locked_e20", 32'(locked_ok), 32'd1);
    chk("nom_retry_e20", 32'(retry_cnt), 32'd0);

    // Loss in RUN: lock low 3 cycles
    pll_lock = 1'b0;
    tick(2);
    chk("loss_run_e2", 32'(state), 32'd3);
    chk("loss_sysrst_e2", 32'(sys_rst_n), 32'd1);
    tick(1);
    chk("loss_state_e3", 32'(state), 32'd0);
    chk("loss_sysrst_e3", 32'(sys_rst_n), 32'd0);
    chk("loss_pllrst_e3", 32'(pll_reset), 32'd1);
    chk("loss_cnt_e3", 32'(loss_cnt), 32'd1);
    pll_lock = 1'b1;
    tick(3);
    chk("loss_pllrst_e6", 32'(pll_reset), 32'd1);
    tick(1);
    chk("loss_wait_e7", 32'(state), 32'd1);
    chk("loss_pllrst_e7", 32'(pll_reset), 32'd0);
    tick(8);
    chk("loss_stable_e15", 32'(state), 32'd2);
    tick(1);
    chk("loss_rerun_e16", 32'(state), 32'd3);

    // Lock loss and restart in the same cycle: the loss is still counted
    pll_lock = 1'b0;
    tick(2);
    chk("lossrs_run_e2", 32'(state), 32'd3);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("lossrs_state", 32'(state), 32'd0);
    chk("lossrs_loss", 32'(loss_cnt), 32'd2);
    chk("lossrs_retry", 32'(retry_cnt), 32'd0);
    pll_lock = 1'b1;
    tick(13);
    chk("lossrs_rerun", 32'(state), 32'd3);

    // Restart in RUN, then restart mid-STABLE
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("rs_run_state", 32'(state), 32'd0);
    chk("rs_run_pllrst", 32'(pll_reset), 32'd1);
    chk("rs_run_loss", 32'(loss_cnt), 32'd2);
    tick(4);
    chk("rs_run_wait", 32'(state), 32'd1);
    tick(2);
    chk("rs_stable", 32'(state), 32'd2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("rs_stable_state", 32'(state), 32'd0);
    chk("rs_stable_pllrst", 32'(pll_reset), 32'd1);
    tick(3);
    chk("rs_stable_full_cnt", 32'(state), 32'd0);
    tick(1);
    chk("rs_stable_wait", 32'(state), 32'd1);
    tick(2);
    chk("rs_stable_again", 32'(state), 32'd2);

    // rst_n mid-STABLE: asynchronous, visible before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async");
    pll_lock = 1'b0;
    tick(2);

    // Chatter: lock sampled high edges 5..9, low 10, high from 11
    rst_n = 1'b1;
    tick(4);
    chk("chat_wait_e4", 32'(state), 32'd1);
    pll_lock = 1'b1;
    tick(3);
    chk("chat_stable_e7", 32'(state), 32'd2);
    tick(2);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    chk("chat_stable_e11", 32'(state), 32'd2);
    tick(1);
    chk("chat_back_wait_e12", 32'(state), 32'd1);
    tick(1);
    chk("chat_stable_e13", 32'(state), 32'd2);
    tick(7);
    chk("chat_stable_e20", 32'(state), 32'd2);
    tick(1);
    chk("chat_run_e21", 32'(state), 32'd3);
    chk("chat_retry_e21", 32'(retry_cnt), 32'd0);

    // Timeout and first synced lock in the same cycle (edge 36): timeout wins
    rst_n = 1'b0;
    pll_lock = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(33);
    chk("tolk_wait_e33", 32'(state), 32'd1);
    pll_lock = 1'b1;
    tick(2);
    chk("tolk_wait_e35", 32'(state), 32'd1);
    tick(1);
    chk("tolk_state_e36", 32'(state), 32'd0);
    chk("tolk_retry_e36", 32'(retry_cnt), 32'd1);
    tick(12);
    chk("tolk_stable_e48", 32'(state), 32'd2);
    tick(1);
    chk("tolk_run_e49", 32'(state), 32'd3);
    chk("tolk_retry_e49", 32'(retry_cnt), 32'd1);

    // No lock: two pulses, two 32-cycle waits, then FAIL
    rst_n = 1'b0;
    pll_lock = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(35);
    chk("nolk_wait_e35", 32'(state), 32'd1);
    chk("nolk_pllrst_e35", 32'(pll_reset), 32'd0);
    tick(1);
    chk("nolk_state_e36", 32'(state), 32'd0);
    chk("nolk_retry_e36", 32'(retry_cnt), 32'd1);
    chk("nolk_pllrst_e36", 32'(pll_reset), 32'd1);
    tick(3);
    chk("nolk_pllrst_e39", 32'(pll_reset), 32'd1);
    tick(1);
    chk("nolk_wait_e40", 32'(state), 32'd1);
    chk("nolk_pllrst_e40", 32'(pll_reset), 32'd0);
    tick(31);
    chk("nolk_wait_e71", 32'(state), 32'd1);
    tick(1);
    chk("nolk_fail_state", 32'(state), 32'd4);
    chk("nolk_fail_flag", 32'(fail), 32'd1);
    chk("nolk_fail_retry", 32'(retry_cnt), 32'd2);
    chk("nolk_fail_sysrst", 32'(sys_rst_n), 32'd0);
    chk("nolk_fail_pllrst", 32'(pll_reset), 32'd0);
    tick(40);
    chk("nolk_fail_hold", 32'(state), 32'd4);
    chk("nolk_fail_hold_sysrst", 32'(sys_rst_n), 32'd0);

    // Restart from FAIL
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("rsf_state", 32'(state), 32'd0);
    chk("rsf_fail", 32'(fail), 32'd0);
    chk("rsf_retry", 32'(retry_cnt), 32'd0);
    chk("rsf_pllrst_e1", 32'(pll_reset), 32'd1);
    tick(3);
    chk("rsf_pllrst_e4", 32'(pll_reset), 32'd1);
    tick(1);
    chk("rsf_wait_e5", 32'(state), 32'd1);
    chk("rsf_pllrst_e5", 32'(pll_reset), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 16: cycles pll_reset is held high per attempt (>=1).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before release (>=1).
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles allowed per attempt to reach RUN (> LOCK_STABLE_CYCLES).
REQ-004 Parameter MAX_RETRIES, default 3: timed-out attempts tolerated before FAIL (1..15).
REQ-005 clk  input  1  free-running reference clock, the PLL input clock (27 MHz); all logic is on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 pll_lock  input  1  PLL LOCK, asynchronous to clk.
REQ-008 restart  input  1  synchronous single-cycle request to restart the sequence.
REQ-009 pll_reset  output  1  drives the PLL RESET pin, active-high.
REQ-010 sys_rst_n  output  1  active-low system reset; high only in RUN.
REQ-011 locked_ok  output  1  high only in RUN.
REQ-012 fail  output  1  high only in FAIL.
REQ-013 retry_cnt  output  4  timed-out attempts in the current sequence.
REQ-014 loss_cnt  output  8  lock losses seen in RUN, saturating at 255.
REQ-015 state  output  3  current state encoding.

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchronizer (lock_s) before any use; lock_s is 0 during reset.
REQ-017 States and encodings SHALL be RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
REQ-018 All outputs SHALL be registered and SHALL decode from the current state only.
REQ-019 RESET_PLL SHALL hold pll_reset=1 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK, clearing the timeout counter on entry.
REQ-020 pll_reset SHALL be 0 in every other state.
REQ-021 WAIT_LOCK SHALL go to STABLE in the first cycle lock_s=1.
REQ-022 STABLE SHALL go to RUN after LOCK_STABLE_CYCLES consecutive cycles with lock_s=1.
REQ-023 In STABLE, any cycle with lock_s=0 SHALL return to WAIT_LOCK and clear the stable counter; the timeout counter is not cleared.
REQ-024 The timeout counter SHALL run in both WAIT_LOCK and STABLE.
REQ-025 When the timeout counter reaches LOCK_TIMEOUT_CYCLES in WAIT_LOCK or STABLE, retry_cnt SHALL increment.
REQ-026 On that timeout, the next state SHALL be FAIL if the new retry_cnt equals MAX_RETRIES, otherwise RESET_PLL.
REQ-027 In RUN, a cycle with lock_s=0 SHALL go to RESET_PLL, increment loss_cnt (saturating) and clear retry_cnt.
REQ-028 sys_rst_n SHALL drop in the cycle after lock_s falls.
REQ-029 FAIL SHALL hold sys_rst_n=0 and pll_reset=0 until restart or rst_n.
REQ-030 restart SHALL have highest priority in every state: go to RESET_PLL with a full RESET_CYCLES count and clear retry_cnt; loss_cnt is kept.
REQ-031 A timeout and lock_s=1 in the same cycle SHALL be treated as timeout; lock loss in RUN together with restart SHALL count the loss.
REQ-032 Counter widths SHALL come from the parameters via $clog2 and SHALL never wrap.

Reset
REQ-033 While rst_n=0: state=RESET_PLL, pll_reset=1, sys_rst_n=0, locked_ok=0, fail=0, retry_cnt=0, loss_cnt=0, all internal counters and sync flops 0.
REQ-034 After rst_n rises, RESET_PLL SHALL run its full RESET_CYCLES count.
REQ-035 Reset asserted mid-operation SHALL force the reset values immediately, asynchronously.

Verification (RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-036 Nominal: pll_lock rises 10 cycles after rst_n release -> pll_reset high exactly 4 cycles; sys_rst_n rises 2+8 cycles after pll_lock rise; state=3; retry_cnt=0.
REQ-037 Chatter: pll_lock high 5 cycles, low 1, then steady -> STABLE returns to WAIT_LOCK once; RUN reached 8 cycles after the final synced rise; no timeout.
REQ-038 No lock: pll_lock held 0 -> two 4-cycle pll_reset pulses separated by 32-cycle waits; then state=4, fail=1, retry_cnt=2, sys_rst_n=0 indefinitely.
REQ-039 Loss in RUN: drop pll_lock for 3 cycles in RUN -> sys_rst_n=0 within 3 cycles; pll_reset pulses 4 cycles; loss_cnt=1; RUN re-entered after re-lock.
REQ-040 Restart from FAIL, and restart and rst_n asserted mid-STABLE -> FAIL exits, retry_cnt=0, 4-cycle pll_reset pulse; rst_n low forces every output to its REQ-033 value in the same cycle.
